// File: rtl/ps2_keyboard_rx_fifo_if.sv
// ps2_keyboard_rx_fifo_if
// CPU-side bundle of the PS/2 keyboard receiver: the FIFO head, occupancy,
// the pop strobe and the one-cycle error pulses.
//   master : the receiver (drives head/status/pulses, samples scanCodeRead)
//   slave  : the keyboard controller (drives scanCodeRead)
// Parameter FIFO_DEPTH must match the receiver instance (sets fifoCount width).
interface ps2_keyboard_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    scanCode;
    logic          scanCodeValid;
    logic          scanCodeRead;
    logic [CW-1:0] fifoCount;
    logic          keyBreak;
    logic          keyExtended;
    logic          parityError;
    logic          frameError;
    logic          overflow;

    modport master (
        output scanCode, scanCodeValid, fifoCount, keyBreak, keyExtended,
               parityError, frameError, overflow,
        input  scanCodeRead
    );

    modport slave (
        input  scanCode, scanCodeValid, fifoCount, keyBreak, keyExtended,
               parityError, frameError, overflow,
        output scanCodeRead
    );
endinterface

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_keyboard_rx_fifo
// PS/2 keyboard receiver, fully in the clk domain: 2-flop synchronisers,
// glitch filter on PS2_CLK, 11-bit frame checker with inactivity timeout,
// and a first-word-fall-through scan-code FIFO.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   PS2_CLK  raw keyboard clock (asynchronous)
//   PS2_DAT  raw keyboard data (asynchronous)
//   kbd      CPU-side interface (master modport): head, valid, count,
//            break/extended flags, pop strobe, error/overflow pulses
// Build option: define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into the
// FIFO entry as keyExtended/keyBreak; otherwise every good byte is queued raw.
//
// State   | meaning
// IDLE    | waiting for a start bit (data 0 at a sample event)
// DATA    | shifting in 8 data bits LSB-first
// PARITY  | capturing the odd-parity result
// STOP    | checking the stop bit, then queue or report an error
module ps2_keyboard_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    ps2_keyboard_rx_fifo_if.master kbd
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          sample_evt, dat_s;
    state_t        state_q, state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_ok_q;
    logic [TW-1:0] to_q;
    logic          timeout_hit, byte_good, par_err, frm_err;
    logic          par_err_q, frm_err_q, ovf_q;
    logic          push_req;
    logic [EW-1:0] push_word;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, do_pop, do_push, ovf;

    // Synchronisers reset to 1 so the bus looks idle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign dat_s = dat_sync_q[1];

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = clk_sync_q[1];
            else                                   filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Sample event is the cycle whose closing edge drops the filtered clock.
    assign sample_evt  = filt_clk_q & ~filt_clk_d;
    assign timeout_hit = (state_q != S_IDLE) && !sample_evt &&
                         (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = S_IDLE;
        end else if (sample_evt) begin
            case (state_q)
                S_IDLE:   if (!dat_s) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Stop-bit failure outranks parity; timeout is reported as a frame error.
    always_comb begin
        byte_good = 1'b0;
        par_err   = 1'b0;
        frm_err   = timeout_hit;
        if (sample_evt && state_q == S_STOP) begin
            if (!dat_s)         frm_err   = 1'b1;
            else if (!par_ok_q) par_err   = 1'b1;
            else                byte_good = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_ok_q  <= 1'b0;
            to_q      <= '0;
        end else begin
            if (sample_evt || state_q == S_IDLE || timeout_hit) to_q <= '0;
            else                                                to_q <= to_q + TW'(1);
            if (sample_evt) begin
                case (state_q)
                    S_IDLE: bit_cnt_q <= '0;
                    S_DATA: begin
                        shift_q   <= {dat_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: par_ok_q <= ^{shift_q, dat_s};
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic ext_q, brk_q, is_prefix;

    assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
    assign push_req  = byte_good && !is_prefix;
    assign push_word = {brk_q, ext_q, shift_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (par_err || frm_err) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_good) begin
            if (shift_q == 8'hE0)      ext_q <= 1'b1;
            else if (shift_q == 8'hF0) brk_q <= 1'b1;
            else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign kbd.keyBreak    = mem_q[rd_ptr_q][9];
    assign kbd.keyExtended = mem_q[rd_ptr_q][8];
`else
    assign push_req        = byte_good;
    assign push_word       = shift_q;
    assign kbd.keyBreak    = 1'b0;
    assign kbd.keyExtended = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = kbd.scanCodeRead && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovf     = push_req && full && !do_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            par_err_q <= par_err;
            frm_err_q <= frm_err;
            ovf_q     <= ovf;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign kbd.scanCode      = mem_q[rd_ptr_q][7:0];
    assign kbd.scanCodeValid = !empty;
    assign kbd.fifoCount     = count_q;
    assign kbd.parityError   = par_err_q;
    assign kbd.frameError    = frm_err_q;
    assign kbd.overflow      = ovf_q;
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
module tb_ps2_keyboard_rx_fifo;
    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;

    ps2_keyboard_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) kbd_if ();

    ps2_keyboard_rx_fifo #(
        .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .kbd(kbd_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Frame-level model: queue of {brk, ext, code}, pending prefix flags,
    // and expected totals of each pulse type.
    logic [9:0] model_q[$];
    bit m_ext = 1'b0, m_brk = 1'b0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (kbd_if.parityError) n_par++;
            if (kbd_if.frameError)  n_frm++;
            if (kbd_if.overflow)    n_ovf++;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("valid", {31'd0, kbd_if.scanCodeValid}, {31'd0, model_q.size() != 0});
            chk("count", 32'(kbd_if.fifoCount), 32'(model_q.size()));
            if (model_q.size() != 0) begin
                chk("head", 32'(kbd_if.scanCode), 32'(model_q[0][7:0]));
                chk("head_brk", {31'd0, kbd_if.keyBreak}, {31'd0, model_q[0][9]});
                chk("head_ext", {31'd0, kbd_if.keyExtended}, {31'd0, model_q[0][8]});
            end
            chk("quiet_pulses", {29'd0, kbd_if.parityError, kbd_if.frameError, kbd_if.overflow}, 32'd0);
        end
    end

    task automatic check_pulses();
        chk("parity_err_total", 32'(n_par), 32'(exp_par));
        chk("frame_err_total", 32'(n_frm), 32'(exp_frm));
        chk("overflow_total", 32'(n_ovf), 32'(exp_ovf));
    endtask

    task automatic deliver(input logic [9:0] e, input bit rd);
        if (rd && model_q.size() != 0) begin
            void'(model_q.pop_front());
            model_q.push_back(e);
        end else if (model_q.size() == DEPTH) exp_ovf++;
        else model_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        PS2_DAT = b;
        if (glitch) begin
            tick(40); PS2_CLK = 1'b0; tick(3); PS2_CLK = 1'b1; tick(37);
        end else tick(80);
        PS2_CLK = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                              input bit rd_at_push, input bit glitch);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) chk_en = 1'b0;
            drive_bit(bits[i], glitch);
            if (i == 10 && rd_at_push) begin
                // 2 sync flops + FILTER_LEN samples: pop on the push edge.
                tick(FL + 1);
                kbd_if.scanCodeRead = 1'b1;
                tick(1);
                kbd_if.scanCodeRead = 1'b0;
                tick(78 - FL);
            end else tick(80);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        tick(80);
        if (!stop) begin
            exp_frm++; m_ext = 0; m_brk = 0;
        end else if (bad_par) begin
            exp_par++; m_ext = 0; m_brk = 0;
        end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                deliver({m_brk, m_ext, b}, rd_at_push);
                m_ext = 0; m_brk = 0;
            end
`else
            deliver({2'b00, b}, rd_at_push);
`endif
        end
        check_pulses();
        chk_en = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] bits;
        chk_en = 1'b0;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(bits[i], 1'b0);
            tick(80);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic read_expect(input logic [7:0] exp);
        chk_en = 1'b0;
        chk("rd_valid", {31'd0, kbd_if.scanCodeValid}, 32'd1);
        chk("rd_data", 32'(kbd_if.scanCode), 32'(exp));
        kbd_if.scanCodeRead = 1'b1;
        tick(1);
        kbd_if.scanCodeRead = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        chk_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scancode"}, 32'(kbd_if.scanCode), 32'd0);
        chk({tag, "_valid"}, {31'd0, kbd_if.scanCodeValid}, 32'd0);
        chk({tag, "_count"}, 32'(kbd_if.fifoCount), 32'd0);
        chk({tag, "_flags"}, {27'd0, kbd_if.keyBreak, kbd_if.keyExtended,
             kbd_if.parityError, kbd_if.frameError, kbd_if.overflow}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        kbd_if.scanCodeRead = 1'b0;
        tick(5);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(20);
        chk_en = 1'b1;

        // Single good frame, then pop.
        send_frame(8'h1C, 0, 1, 0, 0);
        chk("single_code", 32'(kbd_if.scanCode), 32'h1C);
        chk("single_count", 32'(kbd_if.fifoCount), 32'd1);
        read_expect(8'h1C);
        tick(2);
        chk("single_empty", {31'd0, kbd_if.scanCodeValid}, 32'd0);

        // Bad parity, bad stop.
        send_frame(8'h1C, 1, 1, 0, 0);
        chk("par_pulse_lit", 32'(n_par), 32'd1);
        send_frame(8'h1C, 0, 0, 0, 0);
        chk("frm_pulse_lit", 32'(n_frm), 32'd1);

        // Timeout after start + 3 data bits, then a clean 0x2B.
        send_partial(8'h55, 4);
        tick(TO + 100);
        exp_frm++; m_ext = 0; m_brk = 0;
        check_pulses();
        chk("timeout_lit", 32'(n_frm), 32'd2);
        chk_en = 1'b1;
        send_frame(8'h2B, 0, 1, 0, 0);
        chk("after_to_code", 32'(kbd_if.scanCode), 32'h2B);
        read_expect(8'h2B);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, 0, 0);
        chk("full_count", 32'(kbd_if.fifoCount), 32'd4);
        send_frame(8'h05, 0, 1, 0, 0);
        chk("ovf_lit", 32'(n_ovf), 32'd1);
        for (int i = 1; i <= 4; i++) read_expect(8'(i));

        // Full with a pop coinciding with the push: no overflow.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, 0, 0);
        send_frame(8'h05, 0, 1, 1, 0);
        chk("no_ovf_lit", 32'(n_ovf), 32'd1);
        chk("swap_count", 32'(kbd_if.fifoCount), 32'd4);
        for (int i = 2; i <= 5; i++) read_expect(8'(i));

        // Short PS2_CLK glitches must not create sample events.
        send_frame(8'h5A, 0, 1, 0, 1);
        chk("glitch_code", 32'(kbd_if.scanCode), 32'h5A);

        // Reset mid-frame with FIFO occupied.
        send_frame(8'h11, 0, 1, 0, 0);
        send_partial(8'h77, 3);
        rst = 1'b0;
        tick(3);
        check_reset_outputs("midreset");
        model_q.delete();
        m_ext = 0; m_brk = 0;
        rst = 1'b1;
        PS2_CLK = 1'b1;
        tick(20);
        chk_en = 1'b1;
        send_frame(8'h33, 0, 1, 0, 0);
        chk("post_reset_code", 32'(kbd_if.scanCode), 32'h33);
        chk("post_reset_count", 32'(kbd_if.fifoCount), 32'd1);
        read_expect(8'h33);

`ifdef PS2_BREAK_DECODE_EN
        send_frame(8'hE0, 0, 1, 0, 0);
        send_frame(8'hF0, 0, 1, 0, 0);
        send_frame(8'h75, 0, 1, 0, 0);
        chk("brk_count", 32'(kbd_if.fifoCount), 32'd1);
        chk("brk_code", 32'(kbd_if.scanCode), 32'h75);
        chk("brk_flags", {30'd0, kbd_if.keyBreak, kbd_if.keyExtended}, 32'd3);
        read_expect(8'h75);
        send_frame(8'h75, 0, 1, 0, 0);
        chk("make_flags", {30'd0, kbd_if.keyBreak, kbd_if.keyExtended}, 32'd0);
        read_expect(8'h75);
`else
        send_frame(8'hE0, 0, 1, 0, 0);
        chk("raw_e0", 32'(kbd_if.scanCode), 32'hE0);
        chk("raw_flags", {30'd0, kbd_if.keyBreak, kbd_if.keyExtended}, 32'd0);
        read_expect(8'hE0);
`endif

        tick(10);
        chk_en = 1'b0;
        check_pulses();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx_fifo.md
Name: ps2_keyboard_rx_fifo

Overview:
Parametrised successor to the team's PS/2 keyboard receiver. The PS2_CLK/PS2_DAT lines are oversampled entirely in the system clock domain, with synchronisation and glitch filtering. Each 11-bit frame (start, 8 data LSB-first, odd parity, stop) is fully checked, with an inactivity timeout. Good bytes are buffered in a first-word-fall-through FIFO for the CPU-side keyboard controller, so no bytes are lost between polls.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before the filtered PS2_CLK changes level (>=2)
FIFO_DEPTH, 8, scan-code FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 50000, clk cycles without a filtered PS2_CLK falling edge before a partial frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic is in this domain
rst  input  1  asynchronous, active-low reset
PS2_CLK  input  1  raw keyboard clock, asynchronous to clk
PS2_DAT  input  1  raw keyboard data, asynchronous to clk
scanCode  output  8  FIFO head byte; valid only while scanCodeValid=1
scanCodeValid  output  1  FIFO non-empty
scanCodeRead  input  1  pop strobe; honoured only when scanCodeValid=1
fifoCount  output  $clog2(FIFO_DEPTH+1)  entries held
keyBreak  output  1  head entry is a break code (see Optional Feature)
keyExtended  output  1  head entry carries the E0 prefix (see Optional Feature)
parityError  output  1  one-cycle pulse: frame dropped on bad parity
frameError  output  1  one-cycle pulse: frame dropped on bad stop bit or timeout
overflow  output  1  one-cycle pulse: good byte dropped because the FIFO was full

Behaviour:
- Reset: synchroniser flops and the filtered clock/data are set to 1 (bus idle). FSM enters IDLE; bit counter, timeout counter and FIFO pointers clear. All outputs are 0.
- Input path: 2-flop synchroniser on each PS2 line. The filtered level changes only after FILTER_LEN consecutive synchronised samples differ from the current filtered level.
- Sample event: the single cycle in which the filtered PS2_CLK goes 1->0. Data is the synchronised PS2_DAT in that same cycle.
- FSM, advancing only on sample events:
  - IDLE: data=0 -> DATA with bitCnt=0. Data=1 -> stay in IDLE, no error.
  - DATA: shift the bit in LSB-first, bitCnt++. On the 8th bit -> PARITY.
  - PARITY: parOk = XOR(8 data bits, parity bit) == 1 (odd parity). -> STOP.
  - STOP: data=1 and parOk -> push the byte. Data=1 and !parOk -> parityError. Data=0 -> frameError; stop-bit failure takes precedence over parity. -> IDLE in all cases.
- Timeout: the counter clears on every sample event and when in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES outside IDLE: abort to IDLE, pulse frameError, discard the partial byte.
- Push timing: the FIFO is written on the clk edge ending the stop-bit sample-event cycle. scanCodeValid/fifoCount update on the following cycle.
- FIFO (FWFT):
  - scanCode always shows the head entry.
  - Pop occurs when scanCodeRead && scanCodeValid. scanCodeRead while empty is ignored.
  - Push while full with no pop: the byte is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle: both take effect; count is unchanged, including when full, so no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame or with the FIFO occupied: immediate return to the reset state. Frame and FIFO contents are lost.

Optional Feature:
Macro PS2_BREAK_DECODE_EN.
- Defined:
  - Good bytes 0xE0 and 0xF0 are not pushed. They set pending flags ext and brk respectively.
  - The next good non-prefix byte is pushed as the 10-bit entry {brk, ext, code}, and both flags then clear.
  - Pending flags also clear on parityError or frameError. Prefix bytes never cause overflow.
  - keyBreak and keyExtended reflect the head entry.
- Undefined: every good byte, including E0/F0, is pushed raw. FIFO width is 8; keyBreak and keyExtended are tied to 0.

Test Plan:
- Bench drives PS2 frames at 80 clk low / 80 clk high per bit, with FILTER_LEN=8 and FIFO_DEPTH=4.
- Single frame 0x1C, correct parity=0, stop=1 -> scanCodeValid rises; scanCode=0x1C, fifoCount=1; no error pulses. Pulse scanCodeRead -> scanCodeValid=0, fifoCount=0.
- Frame 0x1C with parity=1 -> one parityError pulse; fifoCount stays 0. Frame with stop=0 -> one frameError pulse.
- 3 data bits of a frame, then PS2_CLK held high for TIMEOUT_CYCLES -> frameError pulse, FSM back in IDLE. A following good 0x2B is received correctly.
- Send 0x01..0x05 with no reads -> after the 4th, fifoCount=4; the 5th gives an overflow pulse. Reads return 0x01..0x04 in order. Repeat with scanCodeRead held during the 5th push -> no overflow; final FIFO contents 0x02..0x05.
- Inject 3-cycle low glitches on PS2_CLK between bits -> no extra sample events; byte received intact.
- With PS2_BREAK_DECODE_EN defined, send E0 F0 75 -> one entry: scanCode=0x75, keyBreak=1, keyExtended=1. Then send 75 -> keyBreak=0, keyExtended=0.
